// File: rtl/issue_queue_if.sv
// Fetch-to-decode handshake bundle for the dual-issue instruction queue.
// Fetch pushes up to two instructions per cycle; decode pops the issued lanes.
interface issue_queue_if #(
    parameter int DEPTH = 8
);
    logic                       flush;
    logic [1:0]                 in_valid;
    logic [1:0][31:0]           in_pc;
    logic [1:0][31:0]           in_instr;
    logic [1:0]                 in_jump;
    logic                       in_ready;
    logic [1:0]                 out_valid;
    logic [1:0][31:0]           out_pc;
    logic [1:0][31:0]           out_instr;
    logic                       out_slot;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     count;

    // Driver side: fetch/redirect/decode stimulus.
    modport master (
        output flush,
        output in_valid,
        output in_pc,
        output in_instr,
        output in_jump,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  out_slot,
        input  count
    );

    // Queue side.
    modport slave (
        input  flush,
        input  in_valid,
        input  in_pc,
        input  in_instr,
        input  in_jump,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        output out_slot,
        output count
    );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue instruction queue between fetch and decode, circular buffer.
// Ports: clk, reset (sync, active-high), bus (issue_queue_if.slave).
module issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    issue_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      pcMem    [DEPTH];
    logic [31:0]      instrMem [DEPTH];
    logic [DEPTH-1:0] jumpMem;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head1;
    logic [AW-1:0] wrAddr1;
    logic [CW-1:0] cnt;

    logic          inReady;
    logic          doPush;
    logic          doPop;
    logic [1:0]    pushN;
    logic [1:0]    popN;
    logic [1:0]    issueV;
    logic          slot;

    assign head1   = head + AW'(1);
    // Lane 1 lands at tail alone when lane 0 is empty.
    assign wrAddr1 = tail + AW'(bus.in_valid[0]);

    // Registered count only: a same-cycle pop never opens the input.
    assign inReady = (cnt <= CW'(DEPTH - 2));

    // Issue selection. A jump at head waits for its delay slot and then
    // goes out paired with it; a jump never issues in lane 1 except as
    // a delay slot, where it is treated as an ordinary instruction.
    always_comb begin
        issueV = 2'b00;
        slot   = 1'b0;
        if (cnt == '0) begin
            issueV = 2'b00;
        end else if (jumpMem[head]) begin
            if (cnt >= CW'(2)) begin
                issueV = 2'b11;
                slot   = 1'b1;
            end
        end else if (cnt >= CW'(2) && !jumpMem[head1]) begin
            issueV = 2'b11;
        end else begin
            issueV = 2'b01;
        end
    end

    assign doPush = inReady && !bus.flush;
    assign doPop  = bus.out_ready && !bus.flush;

    assign pushN = doPush
        ? ({1'b0, bus.in_valid[0]} + {1'b0, bus.in_valid[1]})
        : 2'd0;
    assign popN  = doPop
        ? ({1'b0, issueV[0]} + {1'b0, issueV[1]})
        : 2'd0;

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = issueV;
    assign bus.out_slot     = slot;
    assign bus.count        = cnt;
    assign bus.out_pc[0]    = issueV[0] ? pcMem[head]     : 32'd0;
    assign bus.out_pc[1]    = issueV[1] ? pcMem[head1]    : 32'd0;
    assign bus.out_instr[0] = issueV[0] ? instrMem[head]  : 32'd0;
    assign bus.out_instr[1] = issueV[1] ? instrMem[head1] : 32'd0;

    // Entry storage carries no reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            if (bus.in_valid[0]) begin
                pcMem[tail]    <= bus.in_pc[0];
                instrMem[tail] <= bus.in_instr[0];
                jumpMem[tail]  <= bus.in_jump[0];
            end
            if (bus.in_valid[1]) begin
                pcMem[wrAddr1]    <= bus.in_pc[1];
                instrMem[wrAddr1] <= bus.in_instr[1];
                jumpMem[wrAddr1]  <= bus.in_jump[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(popN);
            tail <= tail + AW'(pushN);
            cnt  <= cnt + CW'(pushN) - CW'(popN);
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_issue_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        jump;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   armed = 0;
    ent_t mq[$];
    logic [31:0] got[$];

    issue_queue_if #(.DEPTH(DEPTH)) bus ();

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    // What decode should see, straight from the issue rules.
    function automatic logic [1:0] expOv();
        int n = mq.size();
        if (n == 0) return 2'b00;
        if (mq[0].jump) return (n >= 2) ? 2'b11 : 2'b00;
        if (n >= 2 && !mq[1].jump) return 2'b11;
        return 2'b01;
    endfunction

    task automatic checkOuts();
        logic [1:0] ov;
        logic [31:0] p0, p1, i0, i1;
        if (!armed) return;
        ov = expOv();
        p0 = ov[0] ? mq[0].pc : 32'd0;
        i0 = ov[0] ? mq[0].instr : 32'd0;
        p1 = ov[1] ? mq[1].pc : 32'd0;
        i1 = ov[1] ? mq[1].instr : 32'd0;
        chk("count", bus.count, mq.size());
        chk("inrdy", bus.in_ready, mq.size() <= DEPTH - 2);
        chk("ovld", bus.out_valid, ov);
        chk("slot", bus.out_slot, ov == 2'b11 && mq[0].jump);
        chk("pc0", bus.out_pc[0], p0);
        chk("pc1", bus.out_pc[1], p1);
        chk("ins0", bus.out_instr[0], i0);
        chk("ins1", bus.out_instr[1], i1);
    endtask

    // One clock: check current outputs, drive, clock, update model.
    task automatic cyc(input logic r, input logic f,
                       input logic [1:0] iv, input logic [1:0] ij,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic orr);
        logic [1:0] ov;
        bit rdy;
        ent_t e;
        checkOuts();
        rst = r;
        bus.flush = f;
        bus.in_valid = iv;
        bus.in_jump = ij;
        bus.in_pc[0] = p0;
        bus.in_pc[1] = p1;
        bus.in_instr[0] = mkInstr(p0);
        bus.in_instr[1] = mkInstr(p1);
        bus.out_ready = orr;
        ov = expOv();
        rdy = mq.size() <= DEPTH - 2;
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            if (orr) begin
                if (ov[0]) void'(mq.pop_front());
                if (ov[1]) void'(mq.pop_front());
            end
            if (rdy) begin
                if (iv[0]) begin
                    e.pc = p0; e.instr = mkInstr(p0); e.jump = ij[0];
                    mq.push_back(e);
                end
                if (iv[1]) begin
                    e.pc = p1; e.instr = mkInstr(p1); e.jump = ij[1];
                    mq.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        cyc(1'b1, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic idle(input logic orr);
        cyc(1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, orr);
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 2'b00;
        bus.in_jump = 2'b00;
        bus.in_pc = '0;
        bus.in_instr = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        doReset();
        doReset();
        armed = 1;

        chk("rst_ov", bus.out_valid, 2'b00);
        chk("rst_slot", bus.out_slot, 1'b0);
        chk("rst_pc", bus.out_pc, 64'd0);
        chk("rst_ins", bus.out_instr, 64'd0);
        chk("rst_rdy", bus.in_ready, 1'b1);
        chk("rst_cnt", bus.count, 0);

        // Plain pair issues together.
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h100, 32'h104, 1'b1);
        chk("p_ov", bus.out_valid, 2'b11);
        chk("p_pc0", bus.out_pc[0], 32'h100);
        chk("p_pc1", bus.out_pc[1], 32'h104);
        chk("p_slot", bus.out_slot, 1'b0);
        idle(1'b1);
        chk("p_cnt", bus.count, 0);

        // Jump waits for its delay slot, then pairs with it.
        doReset();
        cyc(1'b0, 1'b0, 2'b11, 2'b10, 32'h200, 32'h204, 1'b1);
        chk("j_ov1", bus.out_valid, 2'b01);
        chk("j_pc1", bus.out_pc[0], 32'h200);
        idle(1'b1);
        chk("j_hold", bus.out_valid, 2'b00);
        chk("j_hcnt", bus.count, 1);
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h208, 32'h20C, 1'b1);
        chk("j_ov2", bus.out_valid, 2'b11);
        chk("j_slot", bus.out_slot, 1'b1);
        chk("j_pc0", bus.out_pc[0], 32'h204);
        chk("j_pcs", bus.out_pc[1], 32'h208);
        idle(1'b1);
        chk("j_ov3", bus.out_valid, 2'b01);
        chk("j_last", bus.out_pc[0], 32'h20C);
        idle(1'b1);

        // Fill to full, drop an overflow push, steady state at 6.
        doReset();
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h300 + 8 * k,
                32'h304 + 8 * k, 1'b0);
            chk("f_cnt", bus.count, 2 * k);
        end
        chk("f_rdy", bus.in_ready, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h3F0, 32'h3F4, 1'b0);
        chk("f_drop", bus.count, 8);
        idle(1'b1);
        chk("f_six", bus.count, 6);
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h3E0, 32'h3E4, 1'b1);
        chk("f_stay", bus.count, 6);

        // Pointer wrap: head parked at 6, five entries straddle the end.
        doReset();
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h380 + 8 * k,
                32'h384 + 8 * k, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1);
        chk("w_empty", bus.count, 0);
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h400, 32'h404, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h408, 32'h40C, 1'b0);
        cyc(1'b0, 1'b0, 2'b01, 2'b00, 32'h410, 32'h0, 1'b0);
        chk("w_cnt", bus.count, 5);
        got.delete();
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid[0]) got.push_back(bus.out_pc[0]);
            if (bus.out_valid[1]) got.push_back(bus.out_pc[1]);
            idle(1'b1);
        end
        chk("w_num", got.size(), 5);
        for (int k = 0; k < got.size() && k < 5; k++)
            chk("w_ord", got[k], 32'h400 + 4 * k);

        // Flush wins over simultaneous push and pop.
        doReset();
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h600, 32'h604, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 2'b00, 32'h608, 32'h60C, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 2'b00, 32'h610, 32'h614, 1'b1);
        chk("fl_cnt", bus.count, 0);
        chk("fl_ov", bus.out_valid, 2'b00);

        // Reset mid-run with a held jump.
        doReset();
        cyc(1'b0, 1'b0, 2'b11, 2'b01, 32'h500, 32'h504, 1'b0);
        cyc(1'b0, 1'b0, 2'b01, 2'b00, 32'h508, 32'h0, 1'b0);
        chk("r_cnt3", bus.count, 3);
        cyc(1'b1, 1'b0, 2'b11, 2'b00, 32'h50C, 32'h510, 1'b1);
        chk("r_cnt", bus.count, 0);
        chk("r_ov", bus.out_valid, 2'b00);
        chk("r_rdy", bus.in_ready, 1'b1);

        // Random traffic against the model.
        begin
            logic [31:0] pcCtr = 32'h1000;
            for (int n = 0; n < 3000; n++) begin
                logic r, f, orr;
                logic [1:0] iv, ij;
                r   = ($urandom_range(0, 149) == 0);
                f   = ($urandom_range(0, 24) == 0);
                iv  = 2'($urandom);
                ij  = {($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0)};
                orr = ($urandom_range(0, 9) < 6);
                cyc(r, f, iv, ij, pcCtr, pcCtr + 4, orr);
                pcCtr = pcCtr + 8;
            end
        end
        checkOuts();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, at least 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  redirect; discard all queued and pushed instructions.
REQ-005 in_valid  input  2  per-lane push valid; lane 0 is older.
REQ-006 in_pc  input  2x32  per-lane PC.
REQ-007 in_instr  input  2x32  per-lane raw instruction.
REQ-008 in_jump  input  2  per-lane predecoded jump/branch flag; the next instruction is its delay slot.
REQ-009 in_ready  output  1  queue can accept two entries this cycle.
REQ-010 out_valid  output  2  per-lane issue valid toward decode; lane 0 is older.
REQ-011 out_pc  output  2x32  per-lane issued PC.
REQ-012 out_instr  output  2x32  per-lane issued instruction.
REQ-013 out_slot  output  1  lane 1 is the delay slot of the jump in lane 0.
REQ-014 out_ready  input  1  decode accepts every asserted out_valid lane this cycle.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer: head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count register; each entry holds pc, instr and jump.
REQ-017 in_ready SHALL equal (count <= DEPTH-2), computed from registered count only; a same-cycle pop SHALL NOT raise it.
REQ-018 A push SHALL occur when in_ready=1 and flush=0; valid lanes are written in age order at tail, tail+1; in_valid=2'b10 SHALL write lane 1 alone at tail.
REQ-019 A push with in_ready=0 SHALL be dropped; fetch is responsible for holding the data.
REQ-020 Issue selection SHALL be combinational from queue state: H0=entry at head, H1=entry at head+1.
REQ-021 If count=0: out_valid=2'b00.
REQ-022 If H0.jump=1: when count>=2, out_valid=2'b11 and out_slot=1; when count=1, out_valid=2'b00, holding the jump until its delay slot arrives.
REQ-023 If H0.jump=0 and count>=2 and H1.jump=0: out_valid=2'b11, out_slot=0.
REQ-024 If H0.jump=0 and either count=1 or H1.jump=1: out_valid=2'b01, out_slot=0. A jump SHALL never issue in lane 1.
REQ-025 A pop SHALL occur when out_ready=1 and flush=0: head advances by popcount(out_valid), with wrap.
REQ-026 Next count SHALL be count + pushed - popped. Simultaneous push and pop SHALL be legal, including at count=DEPTH-2 and count=0, where a push with no pop SHALL be allowed.
REQ-027 Lanes with out_valid=0 SHALL drive out_pc and out_instr to 0; out_slot SHALL be 0 unless out_valid=2'b11.
REQ-028 flush=1 SHALL set head=tail=0 and count=0 on the next edge. Push and pop are ignored in that cycle. Outputs in the flush cycle still reflect the old state, but decode SHALL treat them as killed.
REQ-029 A jump instruction that is itself a delay slot, in lane 1 of a pair, SHALL be issued as an ordinary instruction; no nested pairing.

Reset
REQ-030 On a clock edge with reset=1: head=0, tail=0, count=0. Entry contents SHALL be don't-care.
REQ-031 Immediately after reset: out_valid=2'b00, out_slot=0, out_pc=out_instr=0, in_ready=1, count=0.
REQ-032 reset SHALL take priority over flush, push and pop. Reset asserted mid-operation SHALL discard all entries within one cycle.

Verification
REQ-033 Reset; push {pc 0x100 add, 0x104 sub}, both jump=0; out_ready=1 -> next cycle out_valid=11, pcs 0x100/0x104, out_slot=0, then count returns to 0.
REQ-034 Push {0x200 nop, 0x204 beq jump=1} -> issue 0x200 single (out_valid=01), then a one-entry hold (out_valid=00); push {0x208, 0x20C} -> issue 0x204/0x208 with out_slot=1, then 0x20C.
REQ-035 out_ready=0 with a 2-wide push every cycle from reset -> count 2,4,6,8; in_ready drops to 0 at count=8; a further push is dropped and count stays 8; out_ready=1 at count=6 with a push -> count stays 6.
REQ-036 Fill to count=5 with head=6 (wrap); drain -> PCs emerge in push order across the pointer wrap, with no loss or duplication.
REQ-037 count=4 with flush=1, simultaneous push and out_ready=1 -> next cycle count=0 and out_valid=00; the pushed pair is absent.
REQ-038 Reset asserted at count=3 with a pending jump at head -> next cycle count=0, out_valid=00, in_ready=1.
